// File: rtl/multicycle_cpu.sv
// ---------------------------------------------------------------------------
// multicycle_cpu
//
// Multi-cycle MIPS-subset core. A single FSM steps each instruction through
// FETCH / DECODE / EXEC / MEM / WB and shares one memory port between
// instruction fetch and data access. Every memory transaction uses a
// req/ready handshake, so the memory may insert any number of wait states.
// The core contains its own register file, ALU and program counter.
//
// Supported instructions:
//   R-type add/sub/and/or/slt, lw, sw, beq, addi, j, HALT (opcode 0x3F).
//   Any other opcode or funct sets error and stops the core in HALT.
//
// Parameters:
//   ADDR_WIDTH - byte address width of the PC and mem_addr (8..32)
//   RESET_PC   - PC value loaded on reset and on start
//   NUM_REGS   - number of architectural registers (power of two, 2..32);
//                register fields are reduced modulo NUM_REGS
//
// Ports:
//   clock         in   system clock, all state changes on the rising edge
//   reset         in   synchronous, active-high reset
//   start         in   pulse in IDLE to begin execution at RESET_PC
//   mem_req       out  memory request valid
//   mem_we        out  1 = write, 0 = read (valid with mem_req)
//   mem_addr      out  word-aligned byte address
//   mem_wdata     out  store data
//   mem_rdata     in   read data, valid while mem_ready is high
//   mem_ready     in   transaction completes on an edge with mem_req && mem_ready
//   pc_out        out  current PC
//   busy          out  high in every state except IDLE and HALT
//   halted        out  high in HALT
//   error         out  sticky; illegal instruction or misaligned access
//
// Optional feature (macro MULTICYCLE_CPU_PERF_EN):
//   cycle_count   out  number of busy cycles since reset/start
//   instr_retired out  number of completed instructions since reset/start
// ---------------------------------------------------------------------------
module multicycle_cpu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    NUM_REGS   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  busy,
    output logic                  halted,
    output logic                  error
`ifdef MULTICYCLE_CPU_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instr_retired
`endif
);

    localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_WIDTH-1:0] pc;
    logic [31:0]           ir;
    logic [31:0]           a_reg;
    logic [31:0]           b_reg;
    logic [31:0]           imm_ext;
    logic [31:0]           alu_out;
    logic [31:0]           mdr;
    logic [31:0]           regfile [0:NUM_REGS-1];

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_IDX_W-1:0]  rs_idx;
    logic [REG_IDX_W-1:0]  rt_idx;
    logic [REG_IDX_W-1:0]  rd_idx;
    logic [REG_IDX_W-1:0]  wb_idx;
    logic [31:0]           wb_data;

    logic [31:0]           alu_result;
    logic                  funct_ok;
    logic                  exec_fault;
    logic [31:0]           br_offset;
    logic [31:0]           pc_ext;
    logic [31:0]           jump_target;

    // Instruction fields. Register numbers keep only the low bits so that
    // a smaller register file aliases the 5-bit fields modulo NUM_REGS.
    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign rs_idx = ir[21 +: REG_IDX_W];
    assign rt_idx = ir[16 +: REG_IDX_W];
    assign rd_idx = ir[11 +: REG_IDX_W];

    assign wb_idx  = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
    assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

    // Branch offset is the word offset scaled to bytes; the jump keeps the
    // top nibble of the (already incremented) PC, computed at 32 bits and
    // then truncated to the address width.
    assign br_offset   = {imm_ext[29:0], 2'b00};
    assign pc_ext      = 32'(pc);
    assign jump_target = {pc_ext[31:28], ir[25:0], 2'b00};

    assign pc_out = pc;
    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

    // ALU and instruction legality. Non-R-type instructions always add the
    // sign-extended immediate, which serves both addi and the lw/sw address.
    always_comb begin
        alu_result = a_reg + imm_ext;
        funct_ok   = 1'b1;
        exec_fault = 1'b0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                F_ADD:   alu_result = a_reg + b_reg;
                F_SUB:   alu_result = a_reg - b_reg;
                F_AND:   alu_result = a_reg & b_reg;
                F_OR:    alu_result = a_reg | b_reg;
                F_SLT:   alu_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
                default: funct_ok = 1'b0;
            endcase
        end
        case (opcode)
            OP_RTYPE:                        exec_fault = !funct_ok;
            OP_LW, OP_SW:                    exec_fault = (alu_result[1:0] != 2'b00);
            OP_ADDI, OP_BEQ, OP_J, OP_HALT:  exec_fault = 1'b0;
            default:                         exec_fault = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and memory port drive. The port is a pure function
    // of the registered state, so a reset edge drops mem_req immediately and
    // address/data stay stable for as long as a request waits.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (exec_fault) begin
                    next_state = S_HALT;
                end else begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: next_state = S_WB;
                        OP_LW, OP_SW:      next_state = S_MEM;
                        OP_BEQ, OP_J:      next_state = S_FETCH;
                        default:           next_state = S_HALT;
                    endcase
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OP_SW);
                mem_addr = alu_out[ADDR_WIDTH-1:0];
                if (opcode == OP_SW) begin
                    mem_wdata = b_reg;
                end
                if (mem_ready) begin
                    next_state = (opcode == OP_SW) ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                next_state = S_FETCH;
            end
            S_HALT: begin
                next_state = S_HALT;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath registers. Register 0 is never written and is also forced
    // to read as zero, so it stays zero for any NUM_REGS aliasing.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            imm_ext <= '0;
            alu_out <= '0;
            mdr     <= '0;
            error   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regfile[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc <= RESET_PC;
                    end
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_WIDTH'(4);
                    end
                end
                S_DECODE: begin
                    a_reg   <= (rs_idx == '0) ? 32'h0 : regfile[rs_idx];
                    b_reg   <= (rt_idx == '0) ? 32'h0 : regfile[rt_idx];
                    imm_ext <= {{16{ir[15]}}, ir[15:0]};
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    if (exec_fault) begin
                        error <= 1'b1;
                    end else if ((opcode == OP_BEQ) && (a_reg == b_reg)) begin
                        pc <= pc + br_offset[ADDR_WIDTH-1:0];
                    end else if (opcode == OP_J) begin
                        pc <= jump_target[ADDR_WIDTH-1:0];
                    end
                end
                S_MEM: begin
                    if (mem_ready && (opcode == OP_LW)) begin
                        mdr <= mem_rdata;
                    end
                end
                S_WB: begin
                    if (wb_idx != '0) begin
                        regfile[wb_idx] <= wb_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MULTICYCLE_CPU_PERF_EN
    logic retire;

    // An instruction retires when it leaves its last state: WB, a
    // completing store in MEM, or a branch/jump leaving EXEC. HALT and
    // faulting instructions never retire.
    always_comb begin
        retire = (state == S_WB)
              || ((state == S_MEM) && mem_ready && (opcode == OP_SW))
              || ((state == S_EXEC) && !exec_fault
                  && ((opcode == OP_BEQ) || (opcode == OP_J)));
    end

    // Performance counters, cleared on reset and on an accepted start.
    always_ff @(posedge clock) begin
        if (reset || ((state == S_IDLE) && start)) begin
            cycle_count   <= '0;
            instr_retired <= '0;
        end else begin
            if (busy) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (retire) begin
                instr_retired <= instr_retired + 32'd1;
            end
        end
    end
`endif

endmodule
